// File: rtl/ram_dma.sv
// Purpose : block-transfer initiator (COPY / FILL / SUM) on the 8-bit data RAM port.
// Latency : busy and first access one cycle after start; COPY N done at 2N+1, FILL/SUM N at N+1.
// Backpr. : none; start is sampled only in IDLE and ignored otherwise, including the DONE cycle.
//
// Ports   : clock, reset_s2 (sync, active-high); start/op/src_address/dst_address/length/pattern
//           command inputs; busy/done/error/result status; ram_address/ram_data_in/
//           ram_write_enable drive the RAM, ram_data_out is its combinational read data.
// Build   : define RAM_DMA_SUM_EN to include SUM; without it op=2'b10 is rejected and result is 0.
module ram_dma #(
    parameter logic [7:0] RAM_MIN = 8'h00,
    parameter logic [7:0] RAM_MAX = 8'h79
) (
    input  logic       clock,
    input  logic       reset_s2,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] src_address,
    input  logic [7:0] dst_address,
    input  logic [7:0] length,
    input  logic [7:0] pattern,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] result,
    output logic [7:0] ram_address,
    output logic [7:0] ram_data_in,
    output logic       ram_write_enable,
    input  logic [7:0] ram_data_out
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [1:0] OP_COPY = 2'b00;
    localparam logic [1:0] OP_FILL = 2'b01;
    localparam logic [1:0] OP_SUM  = 2'b10;

    state_t     state, state_n;
    logic [7:0] src_q, src_n, dst_q, dst_n, cnt_q, cnt_n, pat_q, pat_n;
    logic [1:0] op_q, op_n;
    logic       busy_n, done_n, error_n, we_n;
    logic [7:0] addr_n, din_n;
    logic       op_ok, range_ok;

`ifdef RAM_DMA_SUM_EN
    logic [7:0] acc_q, acc_n, result_q, result_n;
    assign result = result_q;
`else
    assign result = 8'h00;
`endif

    // Window check in 9 bits so base+length-1 cannot wrap past 8'hFF.
    // base >= RAM_MIN is written as base+1 > RAM_MIN to keep it a live comparison when RAM_MIN is 0.
    function automatic logic win_ok(input logic [7:0] base, input logic [7:0] len);
        logic [8:0] last;
        last = {1'b0, base} + {1'b0, len} - 9'd1;
        return (({1'b0, base} + 9'd1) > {1'b0, RAM_MIN}) && (last <= {1'b0, RAM_MAX});
    endfunction

    always_comb begin
        op_ok    = 1'b0;
        range_ok = 1'b0;
        case (op)
            OP_COPY: begin
                op_ok    = 1'b1;
                range_ok = win_ok(src_address, length) && win_ok(dst_address, length);
            end
            OP_FILL: begin
                op_ok    = 1'b1;
                range_ok = win_ok(dst_address, length);
            end
`ifdef RAM_DMA_SUM_EN
            OP_SUM: begin
                op_ok    = 1'b1;
                range_ok = win_ok(src_address, length);
            end
`endif
            default: begin
                op_ok    = 1'b0;
                range_ok = 1'b0;
            end
        endcase
    end

    // Next state plus the next value of every registered output: the bus values for the
    // state being entered are computed here so they appear in the cycle that state is active.
    always_comb begin
        state_n = state;
        src_n   = src_q;
        dst_n   = dst_q;
        cnt_n   = cnt_q;
        pat_n   = pat_q;
        op_n    = op_q;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        error_n = error;
        addr_n  = 8'h00;
        din_n   = 8'h00;
        we_n    = 1'b0;
`ifdef RAM_DMA_SUM_EN
        acc_n    = acc_q;
        result_n = result_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    src_n   = src_address;
                    dst_n   = dst_address;
                    cnt_n   = length;
                    pat_n   = pattern;
                    op_n    = op;
                    error_n = 1'b0;
`ifdef RAM_DMA_SUM_EN
                    acc_n    = 8'h00;
                    result_n = 8'h00;
`endif
                    // A zero-length command of a legal op is a no-op whatever its base.
                    if (!op_ok || (length != 8'h00 && !range_ok)) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        error_n = 1'b1;
                    end else if (length == 8'h00) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else if (op == OP_FILL) begin
                        state_n = WRITE;
                        busy_n  = 1'b1;
                        addr_n  = dst_address;
                        din_n   = pattern;
                        we_n    = 1'b1;
                    end else begin
                        state_n = READ;
                        busy_n  = 1'b1;
                        addr_n  = src_address;
                    end
                end
            end
            READ: begin
                if (op_q == OP_COPY) begin
                    // ram_data_in register doubles as the latched read byte.
                    state_n = WRITE;
                    busy_n  = 1'b1;
                    addr_n  = dst_q;
                    din_n   = ram_data_out;
                    we_n    = 1'b1;
                end
`ifdef RAM_DMA_SUM_EN
                else begin
                    acc_n = acc_q + ram_data_out;
                    src_n = src_q + 8'd1;
                    cnt_n = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_n  = DONE;
                        done_n   = 1'b1;
                        result_n = acc_n;
                    end else begin
                        busy_n = 1'b1;
                        addr_n = src_q + 8'd1;
                    end
                end
`endif
            end
            WRITE: begin
                dst_n = dst_q + 8'd1;
                cnt_n = cnt_q - 8'd1;
                if (op_q == OP_COPY) begin
                    src_n = src_q + 8'd1;
                end
                if (cnt_q == 8'd1) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else if (op_q == OP_COPY) begin
                    state_n = READ;
                    busy_n  = 1'b1;
                    addr_n  = src_q + 8'd1;
                end else begin
                    busy_n = 1'b1;
                    addr_n = dst_q + 8'd1;
                    din_n  = pat_q;
                    we_n   = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset_s2) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_s2) begin
            src_q            <= 8'h00;
            dst_q            <= 8'h00;
            cnt_q            <= 8'h00;
            pat_q            <= 8'h00;
            op_q             <= 2'b00;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            ram_address      <= 8'h00;
            ram_data_in      <= 8'h00;
            ram_write_enable <= 1'b0;
`ifdef RAM_DMA_SUM_EN
            acc_q            <= 8'h00;
            result_q         <= 8'h00;
`endif
        end else begin
            src_q            <= src_n;
            dst_q            <= dst_n;
            cnt_q            <= cnt_n;
            pat_q            <= pat_n;
            op_q             <= op_n;
            busy             <= busy_n;
            done             <= done_n;
            error            <= error_n;
            ram_address      <= addr_n;
            ram_data_in      <= din_n;
            ram_write_enable <= we_n;
`ifdef RAM_DMA_SUM_EN
            acc_q            <= acc_n;
            result_q         <= result_n;
`endif
        end
    end

endmodule

// File: tb/tb_ram_dma.sv
// Purpose : self-checking bench for ram_dma with a behavioural RAM and a scoreboard.
// Latency : expectations carry the issue cycle; the monitor checks done timing against it.
// Backpr. : n/a; stimulus waits (bounded) for each command's done before issuing the next.
module tb_ram_dma;

`ifdef RAM_DMA_SUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_s2 = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] src_address = 8'h00, dst_address = 8'h00, length = 8'h00, pattern = 8'h00;
    logic       busy, done, error;
    logic [7:0] result, ram_address, ram_data_in, ram_data_out;
    logic       ram_write_enable;

    ram_dma dut (
        .clock(clock), .reset_s2(reset_s2), .start(start), .op(op),
        .src_address(src_address), .dst_address(dst_address), .length(length),
        .pattern(pattern), .busy(busy), .done(done), .error(error), .result(result),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out)
    );

    always #10 clock = ~clock;

    // Behavioural RAM: synchronous write, combinational read.
    logic [7:0] mem [0:255];
    logic [7:0] ref_mem [0:255];
    assign ram_data_out = mem[ram_address];
    always @(posedge clock) begin
        if (ram_write_enable) mem[ram_address] <= ram_data_in;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         issue;
        int         lat;
        bit         err;
        logic [7:0] res;
        int         writes;
        bit         is_copy;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clock) begin
        if (reset_s2) begin
            wr_cnt = 0;
        end else begin
            if (ram_write_enable) begin
                wr_cnt++;
                if (exp_q.size() != 0 && exp_q[0].is_copy)
                    chk("copy_write_parity", (cyc - exp_q[0].issue) % 2, 0);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc - e.issue, e.lat);
                    chk("error", int'(error), int'(e.err));
                    chk("result", int'(result), int'(e.res));
                    chk("write_count", wr_cnt, e.writes);
                    chk("busy_at_done", int'(busy), 0);
                    chk("bus_idle_at_done", int'({ram_write_enable, ram_address, ram_data_in}), 0);
                end
                wr_cnt = 0;
            end
        end
    end

    task automatic mem_check(input string name);
        int first;
        first = -1;
        for (int i = 0; i < 256; i++)
            if (first < 0 && mem[i] !== ref_mem[i]) first = i;
        total++;
        if (first >= 0) begin
            bad++;
            $display("FAIL %s addr=%0h actual=%0h required=%0h", name, first, mem[first], ref_mem[first]);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", 1, 0);
            exp_q.delete();
        end
    endtask

    // Reference model: decide the outcome from the command rules and apply it to ref_mem.
    task automatic run_cmd(input logic [1:0] o, input logic [7:0] s, input logic [7:0] d,
                           input logic [7:0] l, input logic [7:0] p, input bit poke);
        exp_t e;
        int   si, di, li, acc;
        bit   legal, src_fit, dst_fit;
        si = int'(s); di = int'(d); li = int'(l);
        legal   = (o == 2'b00) || (o == 2'b01) || (o == 2'b10 && SUM_EN);
        src_fit = (si + li - 1) <= 'h79;
        dst_fit = (di + li - 1) <= 'h79;
        e.err = 0; e.res = 8'h00; e.writes = 0; e.lat = 1; e.is_copy = 0;
        if (!legal || (li != 0 && ((o == 2'b00 && !(src_fit && dst_fit)) ||
                                   (o == 2'b01 && !dst_fit) || (o == 2'b10 && !src_fit)))) begin
            e.err = 1;
        end else if (li != 0) begin
            case (o)
                2'b00: begin
                    for (int i = 0; i < li; i++) ref_mem[di + i] = ref_mem[si + i];
                    e.lat = 2 * li + 1; e.writes = li; e.is_copy = 1;
                end
                2'b01: begin
                    for (int i = 0; i < li; i++) ref_mem[di + i] = p;
                    e.lat = li + 1; e.writes = li;
                end
                default: begin
                    acc = 0;
                    for (int i = 0; i < li; i++) acc = (acc + int'(ref_mem[si + i])) % 256;
                    e.res = 8'(acc); e.lat = li + 1;
                end
            endcase
        end
        @(posedge clock); #1;
        op = o; src_address = s; dst_address = d; length = l; pattern = p; start = 1'b1;
        e.issue = cyc;
        exp_q.push_back(e);
        @(posedge clock); #1;
        start = 1'b0;
        if (poke) begin
            repeat (2) @(posedge clock);
            #1;
            op = 2'b01; dst_address = 8'h00; length = 8'h05; pattern = 8'h3C; start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_bus", int'({ram_write_enable, ram_address, ram_data_in}), 0);
        reset_s2 = 1'b0;

        // Directed cases.
        run_cmd(2'b01, 8'h00, 8'h10, 8'd4, 8'hA5, 0);
        mem_check("fill_10");
        @(negedge clock);
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
        ref_mem[0] = 8'h01; ref_mem[1] = 8'h02; ref_mem[2] = 8'h03;
        mem[8'h20] = 8'hFF; mem[8'h21] = 8'h02; mem[8'h22] = 8'h10;
        ref_mem[8'h20] = 8'hFF; ref_mem[8'h21] = 8'h02; ref_mem[8'h22] = 8'h10;
        run_cmd(2'b00, 8'h00, 8'h40, 8'd3, 8'h00, 0);
        mem_check("copy_40");
        run_cmd(2'b10, 8'h20, 8'h00, 8'd3, 8'h00, 0);
        run_cmd(2'b01, 8'h00, 8'h78, 8'd3, 8'h5A, 0);
        run_cmd(2'b01, 8'h00, 8'h30, 8'd1, 8'h77, 0);
        run_cmd(2'b11, 8'h00, 8'h00, 8'd2, 8'h00, 0);
        run_cmd(2'b01, 8'h00, 8'h50, 8'd0, 8'h11, 0);
        run_cmd(2'b00, 8'h05, 8'h06, 8'd4, 8'h00, 0);
        run_cmd(2'b00, 8'h10, 8'h60, 8'd4, 8'h00, 1);
        mem_check("directed");

        // Reset in cycle 3 of a FILL of 8: only the three earlier writes land.
        for (int i = 0; i < 3; i++) ref_mem[8'h68 + i] = 8'hC3;
        @(posedge clock); #1;
        op = 2'b01; dst_address = 8'h68; length = 8'd8; pattern = 8'hC3; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_s2 = 1'b1;
        @(posedge clock); #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_bus", int'({ram_write_enable, ram_address, ram_data_in}), 0);
        chk("midrst_status", int'({error, result}), 0);
        reset_s2 = 1'b0;
        repeat (12) @(posedge clock);
        mem_check("midrst_mem");

        // Randomised commands.
        for (int k = 0; k < 60; k++) begin
            logic [1:0] ro;
            logic [7:0] rs, rd, rl;
            ro = 2'($urandom_range(0, 3));
            rs = 8'($urandom_range(0, 8'h7F));
            rd = 8'($urandom_range(0, 8'h7F));
            rl = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            run_cmd(ro, rs, rd, rl, 8'($urandom), 0);
        end
        mem_check("random_mem");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
